minmax_tracker: RTL and testbench
=================================

// Module: minmax_tracker
// PURPOSE
//  Stream-side consumer of magnitude-compare results. Accepts a frame of unsigned
//  WIDTH-bit samples over a valid/ready handshake. Tracks running max, min, sample
//  count and the number of samples equal to the max. Emits a per-sample eq/gt/lt
//  flag set (sample vs running max), then a one-shot frame report.
//  Sits downstream of the 4-bit magnitude comparator in the datapath test chain;
//  uses the same A_eq_B/A_gt_B/A_lt_B semantics, computed internally.
// PARAMETERS
//  WIDTH   4  sample width, unsigned
//  CNT_W   8  width of count fields; counts saturate at 2**CNT_W-1
// PORTS
//  clk        in   1       single clock, all logic on posedge
//  rst_n      in   1       synchronous, active-low reset
//  in_valid   in   1       sample present
//  in_ready   out  1       block can accept sample
//  in_data    in   WIDTH   sample value
//  in_last    in   1       sample is last of frame
//  cmp_valid  out  1       one-cycle pulse: cmp flags valid
//  A_eq_B     out  1       accepted sample == running max (before update)
//  A_gt_B     out  1       accepted sample >  running max
//  A_lt_B     out  1       accepted sample <  running max
//  out_valid  out  1       frame report valid
//  out_ready  in   1       downstream takes report
//  out_max    out  WIDTH   frame maximum
//  out_min    out  WIDTH   frame minimum
//  out_count  out  CNT_W   samples in frame (saturating)
//  out_nmax   out  CNT_W   samples equal to out_max (saturating)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=EMPTY; every output=0 except in_ready=1.
//  Reset is honoured in any state; a frame or pending report in progress is discarded.
//  Accept = in_valid & in_ready at posedge. Report handoff = out_valid & out_ready.
//  FSM:
//   EMPTY
//    - in_ready=1.
//    - On accept: max=min=in_data, count=1, nmax=1.
//    - Flags: eq=1, gt=0, lt=0.
//    - Next state: HOLD if in_last, else ACCUM.
//   ACCUM
//    - in_ready=1.
//    - On accept, flags compare in_data vs current max; exactly one flag set.
//    - gt: max=in_data, nmax=1.  eq: nmax+1 (sat).  lt: max unchanged.
//    - min=in_data if in_data<min; count+1 (sat).
//    - Next state: HOLD if in_last.
//   HOLD
//    - in_ready=0; out_valid=1.
//    - out_* stable until handoff.
//    - On handoff: next state EMPTY; out_valid=0 next cycle.
//  Latency:
//   - cmp_valid and flags register one cycle after accept (1-cycle pulse); flags
//     hold their last value otherwise.
//   - out_valid rises the cycle after the in_last accept.
//  No back-to-back frame overlap: in_ready=0 for the whole of HOLD, so a new
//  frame's first sample is accepted no earlier than the cycle after handoff.
//  in_valid without in_ready: no state change, no cmp pulse.
//  in_last on the first sample is a one-sample frame: max=min, count=1, nmax=1.
//  Saturation: count and nmax stop at 2**CNT_W-1; max/min tracking continues.
//  All compares unsigned, full WIDTH; no wrap-around.
//  Single-driver rule: exactly one of eq/gt/lt is 1 whenever cmp_valid=1.
// TESTING
//  1. Frame 13,8,6,15,15(last), out_ready=1 -> max=15 min=6 count=5 nmax=2;
//     flags eq,lt,lt,gt,eq.
//  2. Single sample 3 with last -> out_valid next cycle: max=min=3, count=1,
//     nmax=1, eq=1.
//  3. Frame 10,10,10(last), hold out_ready=0 for 5 cycles -> in_ready=0 and
//     report stable throughout (max=10 count=3 nmax=3); handoff then in_ready=1.
//  4. CNT_W=2, frame of 5 samples of 7 -> count=3, nmax=3 (saturated), max=min=7.
//  5. rst_n=0 mid-ACCUM after samples 5,12 -> next cycle EMPTY, outputs 0;
//     frame 4(last) -> max=min=4 count=1.
//  6. Random frames (WIDTH=4) vs reference model -> exact match on every
//     report and cmp pulse.

Source files
------------

// File: rtl/minmax_tracker.sv
// rtl/minmax_tracker.sv - per-frame running max/min/count tracker with compare flags and frame report
//
// Accepts a frame of unsigned WIDTH-bit samples (in_valid/in_ready/in_data/in_last),
// pulses cmp_valid with A_eq_B/A_gt_B/A_lt_B (sample vs running max, before update)
// one cycle after each accept, and presents a frame report (out_max, out_min,
// out_count, out_nmax) on out_valid/out_ready after the last sample.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid, in_ready          sample handshake
//   in_data, in_last            sample value, end-of-frame marker
//   cmp_valid                   one-cycle pulse, flags valid
//   A_eq_B, A_gt_B, A_lt_B      compare flags, hold last value between pulses
//   out_valid, out_ready        frame report handshake
//   out_max, out_min            frame extremes
//   out_count, out_nmax         saturating sample count / count of samples equal to max

module minmax_tracker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             cmp_valid,
    output logic             A_eq_B,
    output logic             A_gt_B,
    output logic             A_lt_B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [WIDTH-1:0] out_min,
    output logic [CNT_W-1:0] out_count,
    output logic [CNT_W-1:0] out_nmax
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t state_r;
    state_t state_nxt;

    logic accept;
    logic handoff;
    logic samp_eq;
    logic samp_gt;
    logic samp_lt;

    assign accept  = in_valid & in_ready;
    assign handoff = out_valid & out_ready;

    // Compare against the running max as it stood before this sample.
    assign samp_eq = (in_data == out_max);
    assign samp_gt = (in_data >  out_max);
    assign samp_lt = (in_data <  out_max);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_r;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_r)
            EMPTY: begin
                in_ready = 1'b1;
                if (accept) begin
                    state_nxt = in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (accept && in_last) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (handoff) begin
                    state_nxt = EMPTY;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmp_valid <= 1'b0;
            A_eq_B    <= 1'b0;
            A_gt_B    <= 1'b0;
            A_lt_B    <= 1'b0;
            out_max   <= '0;
            out_min   <= '0;
            out_count <= '0;
            out_nmax  <= '0;
        end else begin
            cmp_valid <= accept;
            if (accept) begin
                if (state_r == EMPTY) begin
                    // First sample of a frame seeds everything and always reads as equal.
                    A_eq_B    <= 1'b1;
                    A_gt_B    <= 1'b0;
                    A_lt_B    <= 1'b0;
                    out_max   <= in_data;
                    out_min   <= in_data;
                    out_count <= CNT_ONE;
                    out_nmax  <= CNT_ONE;
                end else begin
                    A_eq_B <= samp_eq;
                    A_gt_B <= samp_gt;
                    A_lt_B <= samp_lt;
                    if (samp_gt) begin
                        out_max  <= in_data;
                        out_nmax <= CNT_ONE;
                    end else if (samp_eq && (out_nmax != CNT_MAX)) begin
                        out_nmax <= out_nmax + CNT_ONE;
                    end
                    if (in_data < out_min) begin
                        out_min <= in_data;
                    end
                    if (out_count != CNT_MAX) begin
                        out_count <= out_count + CNT_ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_minmax_tracker.sv
// tb/tb_minmax_tracker.sv - scoreboard bench for minmax_tracker (CNT_W=8 and CNT_W=2 side by side)

module tb_minmax_tracker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_last;
    logic       out_ready;

    logic       in_ready_w [2];
    logic       cmp_valid_w[2];
    logic       eq_w       [2];
    logic       gt_w       [2];
    logic       lt_w       [2];
    logic       out_valid_w[2];
    logic [3:0] max_w      [2];
    logic [3:0] min_w      [2];
    logic [7:0] cnt_w      [2];
    logic [7:0] nmax_w     [2];
    logic [7:0] cnt8, nmax8;
    logic [1:0] cnt2, nmax2;

    assign cnt_w[0]  = cnt8;
    assign nmax_w[0] = nmax8;
    assign cnt_w[1]  = {6'b0, cnt2};
    assign nmax_w[1] = {6'b0, nmax2};

    minmax_tracker #(.WIDTH(4), .CNT_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_w[0]), .in_data(in_data), .in_last(in_last),
        .cmp_valid(cmp_valid_w[0]), .A_eq_B(eq_w[0]), .A_gt_B(gt_w[0]), .A_lt_B(lt_w[0]),
        .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .out_max(max_w[0]), .out_min(min_w[0]), .out_count(cnt8), .out_nmax(nmax8)
    );

    minmax_tracker #(.WIDTH(4), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_w[1]), .in_data(in_data), .in_last(in_last),
        .cmp_valid(cmp_valid_w[1]), .A_eq_B(eq_w[1]), .A_gt_B(gt_w[1]), .A_lt_B(lt_w[1]),
        .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .out_max(max_w[1]), .out_min(min_w[1]), .out_count(cnt2), .out_nmax(nmax2)
    );

    typedef struct packed {
        logic [3:0] mx;
        logic [3:0] mn;
        logic [7:0] c;
        logic [7:0] n;
    } rep_t;

    localparam logic [2:0] F_EQ = 3'b100;
    localparam logic [2:0] F_GT = 3'b010;
    localparam logic [2:0] F_LT = 3'b001;

    logic [2:0] cmp_q[2][$];
    rep_t       rep_q[2][$];

    int vectors     = 0;
    int miscompares = 0;

    logic [2:0] mon_flag;
    rep_t       mon_rep;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops a flag expectation on each cmp pulse, checks the report
    // every HOLD cycle (stability) and pops it on the handoff cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (cmp_valid_w[i]) begin
                if (cmp_q[i].size() == 0) begin
                    chk($sformatf("cmp_unexpected[%0d]", i), cmp_q[i].size(), 1);
                end else begin
                    mon_flag = cmp_q[i].pop_front();
                    chk($sformatf("cmp_flags[%0d]", i), {29'b0, eq_w[i], gt_w[i], lt_w[i]}, {29'b0, mon_flag});
                end
            end
            if (out_valid_w[i]) begin
                if (rep_q[i].size() == 0) begin
                    chk($sformatf("rep_unexpected[%0d]", i), rep_q[i].size(), 1);
                end else begin
                    mon_rep = rep_q[i][0];
                    chk($sformatf("report[%0d]", i),
                        {8'b0, max_w[i], min_w[i], cnt_w[i], nmax_w[i]}, {8'b0, mon_rep});
                    chk($sformatf("in_ready_hold[%0d]", i), {31'b0, in_ready_w[i]}, 0);
                    if (out_ready) begin
                        void'(rep_q[i].pop_front());
                    end
                end
            end
        end
    end

    task automatic send(input logic [3:0] d, input logic last, input logic [2:0] ef);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready_w[0] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("in_ready_timeout", {31'b0, in_ready_w[0]}, 1);
        for (int i = 0; i < 2; i++) cmp_q[i].push_back(ef);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic exp_rep(input logic [3:0] mx, input logic [3:0] mn,
                           input logic [7:0] c8, input logic [7:0] n8,
                           input logic [7:0] c2, input logic [7:0] n2);
        rep_q[0].push_back({mx, mn, c8, n8});
        rep_q[1].push_back({mx, mn, c2, n2});
    endtask

    task automatic drain();
        int n = 0;
        while ((cmp_q[0].size() + cmp_q[1].size() + rep_q[0].size() + rep_q[1].size()) != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("drain_timeout", n, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset_outputs[%0d]", i),
                {2'b0, in_ready_w[i], cmp_valid_w[i], eq_w[i], gt_w[i], lt_w[i], out_valid_w[i],
                 max_w[i], min_w[i], cnt_w[i], nmax_w[i]},
                {2'b0, 1'b1, 29'b0});
        end
        rst_n = 1'b1;
    endtask

    // Reference model state for random frames.
    logic       m_first;
    logic [3:0] m_max, m_min;
    logic [7:0] m_c8, m_n8, m_c2, m_n2;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        do_reset();

        // Frame 13,8,6,15,15
        exp_rep(4'd15, 4'd6, 8'd5, 8'd2, 8'd3, 8'd2);
        send(4'd13, 1'b0, F_EQ);
        send(4'd8,  1'b0, F_LT);
        send(4'd6,  1'b0, F_LT);
        send(4'd15, 1'b0, F_GT);
        send(4'd15, 1'b1, F_EQ);
        drain();

        // Single-sample frame; report must be up the cycle after accept
        exp_rep(4'd3, 4'd3, 8'd1, 8'd1, 8'd1, 8'd1);
        send(4'd3, 1'b1, F_EQ);
        chk("single_out_valid", {31'b0, out_valid_w[0]}, 1);
        drain();

        // Frame 10,10,10 with out_ready low for 5 cycles and in_valid pushing against in_ready=0
        out_ready = 1'b0;
        exp_rep(4'd10, 4'd10, 8'd3, 8'd3, 8'd3, 8'd3);
        send(4'd10, 1'b0, F_EQ);
        send(4'd10, 1'b0, F_EQ);
        send(4'd10, 1'b1, F_EQ);
        in_valid = 1'b1;
        in_data  = 4'd1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_handoff", {31'b0, in_ready_w[0]}, 1);
        chk("out_valid_after_handoff", {31'b0, out_valid_w[0]}, 0);
        drain();

        // Five samples of 7: CNT_W=2 instance saturates at 3
        exp_rep(4'd7, 4'd7, 8'd5, 8'd5, 8'd3, 8'd3);
        for (int k = 0; k < 5; k++) send(4'd7, (k == 4), F_EQ);
        drain();

        // Reset mid-frame discards it
        send(4'd5,  1'b0, F_EQ);
        send(4'd12, 1'b0, F_GT);
        do_reset();
        exp_rep(4'd4, 4'd4, 8'd1, 8'd1, 8'd1, 8'd1);
        send(4'd4, 1'b1, F_EQ);
        drain();

        // Random frames against the reference model
        for (int f = 0; f < 24; f++) begin
            int len;
            int hold;
            len  = $urandom_range(1, 8);
            hold = $urandom_range(0, 3);
            out_ready = (hold == 0);
            m_first = 1'b1;
            for (int k = 0; k < len; k++) begin
                logic [3:0] d;
                logic [2:0] ef;
                d = 4'($urandom_range(0, 15));
                if (m_first) begin
                    ef = F_EQ;
                    m_max = d; m_min = d;
                    m_c8 = 1; m_n8 = 1; m_c2 = 1; m_n2 = 1;
                    m_first = 1'b0;
                end else begin
                    if (d > m_max) begin
                        ef = F_GT;
                        m_max = d;
                        m_n8 = 1; m_n2 = 1;
                    end else if (d == m_max) begin
                        ef = F_EQ;
                        m_n8 = (m_n8 == 8'd255) ? m_n8 : m_n8 + 8'd1;
                        m_n2 = (m_n2 == 8'd3)   ? m_n2 : m_n2 + 8'd1;
                    end else begin
                        ef = F_LT;
                    end
                    if (d < m_min) m_min = d;
                    m_c8 = (m_c8 == 8'd255) ? m_c8 : m_c8 + 8'd1;
                    m_c2 = (m_c2 == 8'd3)   ? m_c2 : m_c2 + 8'd1;
                end
                if (k == len - 1) exp_rep(m_max, m_min, m_c8, m_n8, m_c2, m_n2);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk); #1;
                end
                send(d, (k == len - 1), ef);
            end
            repeat (hold) begin
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
            drain();
        end

        repeat (3) begin
            @(posedge clk); #1;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
